data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised data memory with byte/half/word load-store, sign/zero extension and a valid/ready request port.
- Registered 1-cycle read, per-access error flag, and a self-clearing init sweep after reset.
- Sits between the CPU load-store stage and on-chip RAM.
- Replaces the flat word-only data memory. Parametrised depth, lane-aware writes, no combinational read path.

Parameters:
- DEPTH, 32, number of 32-bit words; any value >= 2.
- ADDR_W, 32, byte-address width of req_addr.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset via the init sweep; 0 = skip the sweep, contents undefined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access rejected; qualified by rsp_valid.
- init_done  out  1  high once the clear sweep has finished.

Behaviour:
- Reset (reset=0, asynchronous) drives all outputs as follows:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - State goes to INIT and the sweep index to 0.
- Reset asserted mid-operation aborts any pending response and restarts INIT. No partial write may complete on the reset edge.
- FSM states: INIT, RUN.
  - INIT: writes 0 to word[idx] each cycle, idx 0..DEPTH-1, with req_ready=0. After idx=DEPTH-1 the block goes to RUN and init_done=1.
  - INIT lasts exactly DEPTH cycles after reset release.
  - With CLEAR_ON_RESET=0, the first edge after reset release goes straight to RUN.
  - RUN: req_ready=1 permanently and init_done stays 1.
- Accept occurs when req_valid && req_ready on a rising edge.
- Throughput is 1 request/cycle. There is no response backpressure.
- Address decode: word index = req_addr[ADDR_W-1:2]; lane offset = req_addr[1:0].
- Error conditions (rsp_err=1, no array change, rsp_rdata=0):
  - word index >= DEPTH;
  - req_size=11.
- Stores write on the accept edge, only to enabled lanes:
  - byte: the lane selected by addr[1:0];
  - half: lanes addr[1]*2 and +1;
  - word: all four lanes.
- Loads read the word on the accept edge. rsp_valid, rsp_rdata and rsp_err become valid on the following edge, so latency is 1 cycle.
- Load extension: the selected lanes are shifted to the LSBs, then sign- or zero-extended to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Store on cycle N followed by a load of the same word on cycle N+1: the load returns the new data. No bypass is needed because the write lands before the second accept edge.
- Responses: rsp_valid=1 for exactly one cycle per accepted request, stores included. With no accept, rsp_valid=0 and rsp_rdata/rsp_err hold 0.
- Without the optional feature, misalignment is tolerated: a half uses addr[1] only and a word ignores addr[1:0].

Optional Feature:
- DATA_MEM_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, gives rsp_err=1, rsp_rdata=0 and no write.
- Undefined: low address bits are truncated as described in Behaviour and no alignment error is raised.

Decomposition:
- Package data_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL;
  - state enum INIT/RUN;
  - WORD_W=32;
  - the lane-count constant.
- One sub-module, data_mem_lane: combinational lane logic that produces the 4-bit write enable and the shifted write word from size, offset and wdata. It also extracts and extends load data.

Test Plan:
- DEPTH=32, CLEAR_ON_RESET=1: release reset, then:
  - req_ready=0 for exactly 32 cycles, then init_done=1;
  - loading word addr 0x7C returns 0x00000000.
- Store word 0x8899AABC at 0x10, then:
  - load byte at 0x11, signed, returns 0xFFFFFFAA;
  - load byte at 0x11, unsigned, returns 0x000000AA;
  - load half at 0x12, signed, returns 0xFFFF8899.
- Store byte 0x5A at 0x21 over word 0x00000000, then word load at 0x20 returns 0x00005A00.
- Back-to-back: store 0x12345678 at 0x08 on cycle N, load 0x08 on N+1 -> rsp_rdata=0x12345678 on N+2, with rsp_valid high on both N+1 and N+2.
- Load at 0x80 (index 32), then size=11 at 0x00 -> rsp_err=1 and rsp_rdata=0 for both. A word load at 0x00 afterwards is unchanged.
- Assert reset mid-stream with a load pending -> rsp_valid drops immediately. After release INIT reruns and the stored words read back 0.
- With DATA_MEM_ALIGN_CHECK_EN: word store at 0x06 -> rsp_err=1 and word 0x04 is unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data memory controller:
//   - data word width and lane count
//   - access size encodings carried on req_size
//   - controller state enum (INIT sweep / RUN)
//   - load extension helper used by the lane logic
// -----------------------------------------------------------------------------
package data_mem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Sign- or zero-extend an LSB-aligned load value to a full word.
    // Word loads pass through untouched; the illegal size yields 0.
    function automatic logic [WORD_W-1:0] extend_load(
        input logic [WORD_W-1:0] raw,
        input logic [1:0]        size,
        input logic              is_unsigned
    );
        logic [WORD_W-1:0] res;
        case (size)
            SZ_BYTE: res = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SZ_HALF: res = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            SZ_WORD: res = raw;
            default: res = {WORD_W{1'b0}};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// -----------------------------------------------------------------------------
// data_mem_lane
// Combinational byte-lane steering for the data memory.
// Ports:
//   size        in  2   access size (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL)
//   offset      in  2   byte offset inside the word (addr[1:0])
//   wdata       in  32  right-aligned store data
//   rword       in  32  raw memory word being loaded
//   is_unsigned in  1   zero-extend (1) or sign-extend (0) sub-word loads
//   be          out 4   per-lane write enable
//   wword       out 32  store data replicated onto its target lanes
//   rdata       out 32  selected lanes shifted to LSBs and extended
// -----------------------------------------------------------------------------
module data_mem_lane
    import data_mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rword,
    input  logic              is_unsigned,
    output logic [LANES-1:0]  be,
    output logic [WORD_W-1:0] wword,
    output logic [WORD_W-1:0] rdata
);

    logic [4:0]        shamt_s;
    logic [WORD_W-1:0] shifted_s;

    // Store steering: replicate the data across the word so every enabled
    // lane already carries the right byte, then pick lanes by size/offset.
    always_comb begin
        be    = 4'b0000;
        wword = {WORD_W{1'b0}};
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << offset;
                wword = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                wword = wdata;
            end
            default: begin
                be    = 4'b0000;
                wword = {WORD_W{1'b0}};
            end
        endcase
    end

    // Load steering: a half only looks at offset[1], a word at neither bit.
    always_comb begin
        shamt_s = 5'd0;
        case (size)
            SZ_BYTE: shamt_s = {offset, 3'b000};
            SZ_HALF: shamt_s = {offset[1], 4'b0000};
            default: shamt_s = 5'd0;
        endcase
        shifted_s = rword >> shamt_s;
        rdata     = extend_load(shifted_s, size, is_unsigned);
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Word-organised data memory with byte/half/word load-store, 1-cycle
// registered response and a post-reset clear sweep.
// Parameters: DEPTH (words, >= 2), ADDR_W (byte-address width),
//             CLEAR_ON_RESET (1 = zero every word after reset).
// Optional build macro: DATA_MEM_ALIGN_CHECK_EN -- flags misaligned half/word
//             accesses as errors instead of truncating the low address bits.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  request accepted this cycle when high
//   req_we       in   1 store / 0 load
//   req_size     in   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned in   zero-extend loads when 1
//   req_addr     in   byte address
//   req_wdata    in   right-aligned store data
//   rsp_valid    out  one-cycle response pulse per accepted request
//   rsp_rdata    out  extended load data (0 for stores/errors/idle)
//   rsp_err      out  access rejected
//   init_done    out  clear sweep finished
// -----------------------------------------------------------------------------
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH          = 32,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    state_e            state_r;
    state_e            state_next_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_next_s;
    logic              ready_r;
    logic              init_done_r;
    logic              rsp_valid_r;
    logic [WORD_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    logic [WORD_W-1:0] mem_r [DEPTH];

    logic [1:0]        offset_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic              out_of_range_s;
    logic              misalign_s;
    logic              err_s;
    logic              accept_s;
    logic              store_wr_s;
    logic              init_wr_s;
    logic [WORD_W-1:0] rd_word_s;
    logic [LANES-1:0]  lane_be_s;
    logic [WORD_W-1:0] lane_wword_s;
    logic [WORD_W-1:0] ld_data_s;

    assign offset_s  = req_addr[1:0];
    assign mem_idx_s = req_addr[IDX_W+1:2];
    assign rd_word_s = mem_r[mem_idx_s];

    data_mem_lane u_lane (
        .size        (req_size),
        .offset      (offset_s),
        .wdata       (req_wdata),
        .rword       (rd_word_s),
        .is_unsigned (req_unsigned),
        .be          (lane_be_s),
        .wword       (lane_wword_s),
        .rdata       (ld_data_s)
    );

    // Request decode: accept, range/size/alignment errors, write strobes.
    always_comb begin
        accept_s       = req_valid & ready_r;
        out_of_range_s = ({2'b00, req_addr[ADDR_W-1:2]} >= DEPTH_A);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        if (req_size == SZ_HALF) begin
            misalign_s = offset_s[0];
        end else if (req_size == SZ_WORD) begin
            misalign_s = (offset_s != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
        err_s      = out_of_range_s | (req_size == SZ_ILLEGAL) | misalign_s;
        store_wr_s = accept_s & req_we & ~err_s;
        init_wr_s  = (state_r == INIT) && (CLEAR_ON_RESET != 32'sd0);
    end

    // Next-state logic for the clear sweep and steady-state operation.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            INIT: begin
                if (CLEAR_ON_RESET == 32'sd0) begin
                    state_next_s = RUN;
                end else if (idx_r == IDX_LAST) begin
                    state_next_s = RUN;
                end else begin
                    idx_next_s = idx_r + IDX_W'(1);
                end
            end
            RUN: begin
                state_next_s = RUN;
            end
            default: begin
                state_next_s = INIT;
                idx_next_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Control and response registers; responses are captured on the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= INIT;
            idx_r       <= {IDX_W{1'b0}};
            ready_r     <= 1'b0;
            init_done_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {WORD_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            ready_r     <= (state_next_s == RUN);
            init_done_r <= (state_next_s == RUN);
            rsp_valid_r <= accept_s;
            rsp_err_r   <= accept_s & err_s;
            if (accept_s && !err_s && !req_we) begin
                rsp_rdata_r <= ld_data_s;
            end else begin
                rsp_rdata_r <= {WORD_W{1'b0}};
            end
        end
    end

    // Storage array: the sweep clears whole words, stores touch enabled lanes.
    // Stores need ready_r, which reset forces low, so none land during reset.
    always_ff @(posedge clk) begin
        if (init_wr_s) begin
            mem_r[idx_r] <= {WORD_W{1'b0}};
        end else if (store_wr_s) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_be_s[l]) begin
                    mem_r[mem_idx_s][l*8 +: 8] <= lane_wword_s[l*8 +: 8];
                end
            end
        end
    end

    assign req_ready = ready_r;
    assign init_done = init_done_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed plus randomized checks of data_mem_ctrl (DEPTH=32, clear on reset)
// against a byte-addressed reference memory.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [DEPTH*4];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    endtask

    // Reference: byte-addressed memory, little-endian, rules taken directly
    // from the access description (size -> byte count, truncated base address).
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rd);
        int          n;
        logic [31:0] base;
        logic [31:0] v;
        logic        misal;
        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base  = addr - (addr % n);
        misal = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        misal = (sz != 2'd0) && (sz != 2'd3) && ((addr % n) != 0);
`endif
        err = (sz == 2'd3) || ((addr / 4) >= DEPTH) || misal;
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < n; k++) ref_mem[base + k] = wdata[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[base + k];
                if (!uns && n < 4 && v[8*n-1]) begin
                    for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
                end
                rd = v;
            end
        end
    endtask

    // Present one request, let it be accepted, check the response next cycle.
    // req_valid is left high so consecutive calls are back-to-back.
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic        e;
        logic [31:0] r;
        model(we, sz, uns, addr, wdata, e, r);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk); #1;
        chk({tag, ".valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, ".err"},   {31'h0, rsp_err},   {31'h0, e});
        chk({tag, ".rdata"}, rsp_rdata, r);
    endtask

    task automatic idle(input string tag);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".idle_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, ".idle_rdata"}, rsp_rdata, 32'h0);
        chk({tag, ".idle_err"},   {31'h0, rsp_err}, 32'h0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".init_cycles"}, n, DEPTH);
        chk({tag, ".init_done"}, {31'h0, init_done}, 32'h1);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        clear_ref();

        // Reset state
        #3;
        chk("rst.ready", {31'h0, req_ready}, 32'h0);
        chk("rst.valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst.rdata", rsp_rdata, 32'h0);
        chk("rst.err",   {31'h0, rsp_err}, 32'h0);
        chk("rst.init",  {31'h0, init_done}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        wait_init("boot");

        do_req("ld7c", 1'b0, 2'd2, 1'b0, 32'h7C, 32'h0);
        chk("ld7c.zero", rsp_rdata, 32'h0);

        do_req("st10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABC);
        do_req("lb11s", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        chk("lb11s.const", rsp_rdata, 32'hFFFFFFAA);
        do_req("lb11u", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        chk("lb11u.const", rsp_rdata, 32'h000000AA);
        do_req("lh12s", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        chk("lh12s.const", rsp_rdata, 32'hFFFF8899);
        idle("gap1");

        do_req("sb21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000005A);
        do_req("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        chk("lw20.const", rsp_rdata, 32'h00005A00);
        idle("gap2");

        // Back-to-back store then load of the same word
        do_req("b2b.st", 1'b1, 2'd2, 1'b0, 32'h08, 32'h12345678);
        do_req("b2b.ld", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
        chk("b2b.const", rsp_rdata, 32'h12345678);

        // Errors: out-of-range index and illegal size (as a store)
        do_req("oor", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        chk("oor.err", {31'h0, rsp_err}, 32'h1);
        do_req("ill", 1'b1, 2'd3, 1'b0, 32'h00, 32'hDEADBEEF);
        chk("ill.err", {31'h0, rsp_err}, 32'h1);
        do_req("lw00", 1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
        chk("lw00.const", rsp_rdata, 32'h0);
        idle("gap3");

        // Misaligned word store (error with alignment check, truncated otherwise)
        do_req("st06", 1'b1, 2'd2, 1'b0, 32'h06, 32'hCAFEF00D);
        do_req("lw04", 1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        chk("lw04.const", rsp_rdata, 32'h0);
`else
        chk("lw04.const", rsp_rdata, 32'hCAFEF00D);
`endif
        idle("gap4");

        // Randomized traffic with occasional idle cycles
        for (int i = 0; i < 400; i++) begin
            a = $urandom_range(0, DEPTH*4 + 15);
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                idle("rnd");
            end else begin
                do_req("rnd", 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
            end
        end

        // Mid-stream reset with a load response pending
        do_req("pre_rst.st", 1'b1, 2'd2, 1'b0, 32'h10, 32'h0BADF00D);
        do_req("pre_rst.ld", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        reset = 1'b0;
        #1;
        chk("mid_rst.valid", {31'h0, rsp_valid}, 32'h0);
        chk("mid_rst.ready", {31'h0, req_ready}, 32'h0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_ref();
        wait_init("reboot");
        do_req("post.lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("post.lw10.const", rsp_rdata, 32'h0);
        do_req("post.lw08", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
        chk("post.lw08.const", rsp_rdata, 32'h0);
        do_req("post.lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        chk("post.lw20.const", rsp_rdata, 32'h0);
        idle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
